// File: rtl/fetch_issue.sv
// fetch_issue: single-outstanding instruction fetch with branch redirect, stall hold and halt.
module fetch_issue (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_rd,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [7:0]  br_target,
  output logic        id_valid,
  output logic [3:0]  op,
  output logic        r,
  output logic [1:0]  ls,
  output logic [1:0]  ad,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [7:0]  id_pc,
  output logic        halted
);
  typedef enum logic [1:0] {FETCH, DROP, ISSUE, HALT} state_t;
  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d, id_pc_q, id_pc_d;
  logic [15:0] ir_q, ir_d;
  logic        id_valid_q, id_valid_d, halted_q, halted_d, first_q, first_d;
  logic        eff_valid, unused_bit;
  // a strobe in the first cycle after reset belongs to an abandoned request
  assign eff_valid  = imem_valid && !first_q;
  assign unused_bit = ir_q[3];
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    ir_d       = ir_q;
    id_valid_d = id_valid_q;
    halted_d   = halted_q;
    first_d    = 1'b0;
    case (state_q)
      FETCH:
        if (br_taken) begin
          pc_d    = br_target;
          state_d = eff_valid ? FETCH : DROP;
        end else if (eff_valid) begin
          ir_d       = imem_data;
          id_pc_d    = pc_q;
          pc_d       = pc_q + 8'd1;
          id_valid_d = 1'b1;
          state_d    = ISSUE;
        end
      DROP: state_d = imem_valid ? FETCH : DROP;
      ISSUE:
        if (br_taken) begin
          id_valid_d = 1'b0;
          pc_d       = br_target;
          state_d    = FETCH;
        end else if (!stall) begin
          id_valid_d = 1'b0;
          halted_d   = ir_q[15:12] == 4'd0;
          state_d    = ir_q[15:12] == 4'd0 ? HALT : FETCH;
        end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= 8'd0;
      id_pc_q    <= 8'd0;
      ir_q       <= 16'd0;
      id_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      ir_q       <= ir_d;
      id_valid_q <= id_valid_d;
      halted_q   <= halted_d;
      first_q    <= first_d;
    end
  end
  assign imem_rd   = rst_n && state_q == FETCH;
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign op        = ir_q[15:12];
  assign rd        = ir_q[11:8];
  assign rs        = ir_q[7:4];
  assign r         = ir_q[2];
  assign ls        = ir_q[1:0];
  assign ad        = ir_q[1:0];
  assign id_pc     = id_pc_q;
  assign halted    = halted_q;
endmodule

// File: tb/tb_fetch_issue.sv
// tb_fetch_issue: directed stimulus with a queue scoreboard checked by an issue monitor.
module tb_fetch_issue;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_rd, imem_valid = 1'b0, stall = 1'b0, br_taken = 1'b0;
  logic [7:0]  imem_addr, br_target = 8'd0, id_pc;
  logic [15:0] imem_data = 16'd0;
  logic        id_valid, r, halted;
  logic [3:0]  op, rd, rs;
  logic [1:0]  ls, ad;
  int          vectors = 0, miscompares = 0;

  typedef struct packed {
    logic [3:0] op, rd, rs;
    logic       r;
    logic [1:0] ls, ad;
    logic [7:0] pc;
  } issue_t;
  issue_t exp_q[$];

  fetch_issue dut (
    .clk(clk), .rst_n(rst_n), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_valid(imem_valid), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .id_valid(id_valid),
    .op(op), .r(r), .ls(ls), .ad(ad), .rd(rd), .rs(rs), .id_pc(id_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic respond(input logic [15:0] d, input issue_t e, input bit expect_issue);
    imem_valid = 1'b1;
    imem_data  = d;
    if (expect_issue) exp_q.push_back(e);
    step();
    imem_valid = 1'b0;
  endtask

  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (id_valid && !prev_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_issue: got op=%0h pc=%0h expected no issue", op, id_pc);
      end else begin
        issue_t e, a;
        e = exp_q.pop_front();
        a = '{op: op, rd: rd, rs: rs, r: r, ls: ls, ad: ad, pc: id_pc};
        if (a !== e) begin
          miscompares++;
          $display("FAIL issue_fields: got %h expected %h", a, e);
        end
      end
    end
    prev_valid = id_valid;
  end

  initial begin
    step();
    step();
    chk("rst_imem_rd", imem_rd, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_id_pc", id_pc, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rd", imem_rd, 1);
    chk("post_rst_addr", imem_addr, 0);
    respond(16'hFFFF, '0, 0);
    chk("late_valid_ignored", id_valid, 0);
    chk("late_valid_addr", imem_addr, 0);
    step();
    respond(16'h1234, '{op: 4'h1, rd: 4'h2, rs: 4'h3, r: 1'b1, ls: 2'd0, ad: 2'd0, pc: 8'h00}, 1);
    chk("basic_id_valid", id_valid, 1);
    step();
    chk("basic_consumed", id_valid, 0);
    chk("basic_next_rd", imem_rd, 1);
    chk("basic_next_addr", imem_addr, 8'h01);
    step();
    stall = 1'b1;
    respond(16'hE002, '{op: 4'hE, rd: 4'h0, rs: 4'h0, r: 1'b0, ls: 2'd2, ad: 2'd2, pc: 8'h01}, 1);
    for (int i = 0; i < 4; i++) begin
      chk("stall_id_valid", id_valid, 1);
      chk("stall_no_rd", imem_rd, 0);
      chk("stall_ls", ls, 2'd2);
      chk("stall_op", op, 4'hE);
      if (i == 3) stall = 1'b0;
      step();
    end
    chk("stall_release", id_valid, 0);
    chk("stall_next_addr", imem_addr, 8'h02);
    step();
    br_taken  = 1'b1;
    br_target = 8'h40;
    step();
    br_taken = 1'b0;
    chk("drop_no_rd", imem_rd, 0);
    step();
    respond(16'h5555, '0, 0);
    chk("drop_no_issue", id_valid, 0);
    chk("drop_rd", imem_rd, 1);
    chk("drop_addr", imem_addr, 8'h40);
    step();
    respond(16'h3111, '{op: 4'h3, rd: 4'h1, rs: 4'h1, r: 1'b0, ls: 2'd1, ad: 2'd1, pc: 8'h40}, 1);
    stall     = 1'b1;
    br_taken  = 1'b1;
    br_target = 8'h80;
    step();
    br_taken = 1'b0;
    stall    = 1'b0;
    chk("br_over_stall_valid", id_valid, 0);
    chk("br_over_stall_rd", imem_rd, 1);
    chk("br_over_stall_addr", imem_addr, 8'h80);
    br_taken  = 1'b1;
    br_target = 8'h90;
    respond(16'h7777, '0, 0);
    br_taken = 1'b0;
    chk("br_with_valid_rd", imem_rd, 1);
    chk("br_with_valid_addr", imem_addr, 8'h90);
    chk("br_with_valid_no_issue", id_valid, 0);
    br_taken  = 1'b1;
    br_target = 8'hFF;
    step();
    br_taken = 1'b0;
    respond(16'hAAAA, '0, 0);
    chk("halt_fetch_addr", imem_addr, 8'hFF);
    step();
    respond(16'h0000, '{op: 4'h0, rd: 4'h0, rs: 4'h0, r: 1'b0, ls: 2'd0, ad: 2'd0, pc: 8'hFF}, 1);
    chk("halt_id_pc", id_pc, 8'hFF);
    step();
    chk("halted_set", halted, 1);
    chk("halted_id_valid", id_valid, 0);
    br_taken   = 1'b1;
    stall      = 1'b1;
    imem_valid = 1'b1;
    step();
    step();
    chk("halted_rd", imem_rd, 0);
    chk("halted_hold", halted, 1);
    br_taken   = 1'b0;
    stall      = 1'b0;
    imem_valid = 1'b0;
    rst_n      = 1'b0;
    step();
    chk("rerst_halted", halted, 0);
    chk("rerst_rd", imem_rd, 0);
    rst_n = 1'b1;
    #1;
    chk("rerst_fetch_rd", imem_rd, 1);
    chk("rerst_fetch_addr", imem_addr, 8'h00);
    br_taken  = 1'b1;
    br_target = 8'hFF;
    step();
    br_taken = 1'b0;
    respond(16'hBBBB, '0, 0);
    step();
    respond(16'h2AB5, '{op: 4'h2, rd: 4'hA, rs: 4'hB, r: 1'b1, ls: 2'd1, ad: 2'd1, pc: 8'hFF}, 1);
    step();
    chk("wrap_rd", imem_rd, 1);
    chk("wrap_addr", imem_addr, 8'h00);
    step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_issue.md
FETCH_ISSUE -- requirements
Module: fetch_issue

Interface
REQ-001 SHALL have one clock and synchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-002 SHALL have imem_rd  out  1  instruction-memory read request, held until imem_valid.
REQ-003 SHALL have imem_addr  out  8  word address of request, stable while imem_rd=1.
REQ-004 SHALL have imem_data  in  16  instruction word, sampled only when imem_valid=1.
REQ-005 SHALL have imem_valid  in  1  one-cycle response strobe for the outstanding request.
REQ-006 SHALL have stall  in  1  decode/control not ready; holds the issued instruction.
REQ-007 SHALL have br_taken  in  1  redirect request; br_target  in  8  redirect address.
REQ-008 SHALL have id_valid  out  1  issue fields are valid this cycle.
REQ-009 SHALL have op  out  4; r  out  1; ls  out  2; ad  out  2; rd  out  4; rs  out  4; fields driven into control.
REQ-010 SHALL have id_pc  out  8  address of the issued instruction; halted  out  1  halt reached.

Function
REQ-011 SHALL split the instruction as op=[15:12], rd=[11:8], rs=[7:4], r=[2], ls=[1:0], ad=[1:0] (ls used by op 1110, ad by op 1111).
REQ-012 SHALL keep an 8-bit pc, incremented modulo 256 (0xFF -> 0x00).
REQ-013 SHALL implement states FETCH, DROP, ISSUE, HALT, with at most one outstanding memory request.
REQ-014 FETCH: imem_rd=1, imem_addr=pc; on imem_valid, register fields, id_pc<=pc, pc<=pc+1, id_valid<=1, go to ISSUE.
REQ-015 ISSUE: imem_rd=0; stall=1 holds all fields and id_valid=1 unchanged; stall=0 consumes the instruction that cycle.
REQ-016 On consume, op=0000 SHALL go to HALT and set halted=1 next cycle; any other op SHALL go to FETCH; id_valid=0 next cycle in both cases.
REQ-017 Latency: imem_valid in cycle N SHALL give id_valid=1 in cycle N+1; consume in cycle M SHALL give imem_rd=1 for the next pc in cycle M+1.
REQ-018 br_taken in FETCH without imem_valid SHALL set pc<=br_target, drop imem_rd, and go to DROP.
REQ-019 br_taken in FETCH with imem_valid in the same cycle SHALL discard the data, set pc<=br_target, and go to FETCH.
REQ-020 DROP: imem_rd=0; the next imem_valid SHALL be discarded and the state SHALL go to FETCH at the redirected pc.
REQ-021 br_taken in ISSUE SHALL override stall: id_valid<=0, pc<=br_target, go to FETCH.
REQ-022 HALT: imem_rd=0, id_valid=0, halted=1; br_taken, stall and imem_valid ignored; only reset exits.
REQ-023 Fields and id_pc SHALL hold their last value whenever id_valid=0.

Reset
REQ-024 While rst_n=0 at a clock edge: state<=FETCH, pc<=0, id_valid, op, r, ls, ad, rd, rs, id_pc, halted <=0; imem_rd SHALL be 0 during reset.
REQ-025 First cycle after reset release SHALL drive imem_rd=1, imem_addr=0x00.
REQ-026 Reset mid-operation SHALL abandon any outstanding request; a late imem_valid in the first post-reset cycle before a new request is ignored.

Verification
REQ-027 Reset, memory returns 0x1234 one cycle after request, stall=0 -> id_valid=1 for one cycle with op=1, rd=2, rs=3, r=1, ls=ad=00, id_pc=0x00; next cycle imem_addr=0x01.
REQ-028 Issue 0xE002 (ls=10) with stall=1 for 3 cycles -> op=1110, ls=10, id_valid=1 held 4 cycles, imem_rd=0 throughout, then fetch at pc+1.
REQ-029 br_taken with br_target=0x40 while a request is outstanding, memory responds 2 cycles later -> response discarded, no id_valid, next imem_addr=0x40.
REQ-030 br_taken=1 and stall=1 in ISSUE -> id_valid=0 next cycle, imem_rd=1 with imem_addr=br_target.
REQ-031 pc=0xFF issuing 0x0000 -> id_pc=0xFF, then halted=1, imem_rd stays 0 despite br_taken; pulse rst_n=0 -> halted=0, fetch at 0x00.
REQ-032 Branch to 0xFF, issue non-halt op -> next imem_addr=0x00 (wrap).
